book_feed_arbiter: RTL and testbench

// Round-robin scheduler that shares the single order_book update port among
//   NUM_SRC parsed-message FIFOs (one per parser lane).

---
 rtl/book_feed_arbiter.sv | 139 +++++++++++++
 tb/tb_book_feed_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/book_feed_arbiter.sv
// book_feed_arbiter: round-robin scheduler that moves one parsed message at a
// time from NUM_SRC parser FIFOs into the single order_book update port.
// parsed_msg_t is carried as a flat MSG_W-bit vector:
//   {msg_type[7:0], side[7:0], pad[15:0], order_id[31:0], price[31:0], qty[31:0]}
module book_feed_arbiter #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned FIFO_LAT = 1,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MSG_W    = 128,
    localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_empty,
    input  logic [NUM_SRC-1:0][MSG_W-1:0] src_msg,
    output logic [NUM_SRC-1:0]            src_read_en,
    output logic [MSG_W-1:0]              book_msg,
    output logic                          book_read_en,
    output logic                          book_empty,
    input  logic                          book_busy,
    output logic [ID_W-1:0]               grant_id,
    output logic [NUM_SRC-1:0][CNT_W-1:0] grant_cnt
);

    typedef enum logic [2:0] {StIdle, StPop, StLoad, StIssue, StWait} state_e;

    // Last POP cycle index; the FIFO head is valid in the cycle after it.
    localparam logic [1:0] LatLast = 2'(FIFO_LAT - 1);

    state_e                        state_q, state_d;
    logic [ID_W-1:0]               grant_q, grant_d;
    logic [ID_W-1:0]               rr_q, rr_d;
    logic [1:0]                    lat_q, lat_d;
    logic [MSG_W-1:0]              msg_q;
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q;

    logic                          req_any;
    logic [ID_W-1:0]               pick;
    logic [ID_W-1:0]               cand;
    int unsigned                   idx;

    // Round-robin pick: first requester strictly after the last served source.
    always_comb begin
        req_any = 1'b0;
        pick    = '0;
        cand    = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx  = (32'(rr_q) + k) % NUM_SRC;
            cand = ID_W'(idx);
            if (!req_any && !src_empty[cand]) begin
                req_any = 1'b1;
                pick    = cand;
            end
        end
    end

    // Next-state and strobe decode; strobes are pure functions of state.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        lat_d        = lat_q;
        src_read_en  = '0;
        book_read_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    grant_d = pick;
                    lat_d   = '0;
                    state_d = StPop;
                end
            end
            StPop: begin
                // Pop only on the first POP cycle, then wait out the FIFO latency.
                if (lat_q == '0) begin
                    src_read_en[grant_q] = 1'b1;
                end
                if (lat_q == LatLast) begin
                    state_d = StLoad;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StLoad: begin
                state_d = StIssue;
            end
            StIssue: begin
                book_read_en = 1'b1;
                rr_d         = grant_q;
                state_d      = StWait;
            end
            StWait: begin
                if (!book_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        book_empty = !book_read_en;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= ID_W'(NUM_SRC - 1);
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            lat_q   <= lat_d;
        end
    end

    // Message capture in LOAD and per-source delivery counters bumped in ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_q <= '0;
            cnt_q <= '0;
        end else begin
            if (state_q == StLoad) begin
                msg_q <= src_msg[grant_q];
            end
            if (state_q == StIssue) begin
                cnt_q[grant_q] <= cnt_q[grant_q] + CNT_W'(1);
            end
        end
    end

    assign book_msg  = msg_q;
    assign grant_id  = grant_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_book_feed_arbiter.sv
// Bench for book_feed_arbiter: directed sequences, an arbitration vector
// table and randomized runs checked against a transaction-level model.
module tb_book_feed_arbiter;

    localparam int NS = 4;
    localparam int MW = 128;

    localparam logic [7:0] ADD = 8'h01;
    localparam logic [7:0] BID = 8'h00;
    localparam logic [7:0] ASK = 8'h01;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NS-1:0]        src_empty;
    logic [NS-1:0][MW-1:0] src_msg;
    logic [NS-1:0]        src_read_en;
    logic [MW-1:0]        book_msg;
    logic                 book_read_en;
    logic                 book_empty;
    logic                 book_busy;
    logic [1:0]           grant_id;
    logic [NS-1:0][15:0]  grant_cnt;

    // Second instance built with FIFO_LAT=2, driven by hand.
    logic [NS-1:0]        src_empty2;
    logic [NS-1:0][MW-1:0] src_msg2;
    logic [NS-1:0]        src_read_en2;
    logic [MW-1:0]        book_msg2;
    logic                 book_read_en2;
    logic                 book_empty2;
    logic                 book_busy2;
    logic [1:0]           grant_id2;
    logic [NS-1:0][15:0]  grant_cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    book_feed_arbiter #(.NUM_SRC(4), .FIFO_LAT(1), .CNT_W(16), .MSG_W(128)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .src_empty    (src_empty),
        .src_msg      (src_msg),
        .src_read_en  (src_read_en),
        .book_msg     (book_msg),
        .book_read_en (book_read_en),
        .book_empty   (book_empty),
        .book_busy    (book_busy),
        .grant_id     (grant_id),
        .grant_cnt    (grant_cnt)
    );

    book_feed_arbiter #(.NUM_SRC(4), .FIFO_LAT(2), .CNT_W(16), .MSG_W(128)) u_dut2 (
        .clk          (clk),
        .reset        (reset),
        .src_empty    (src_empty2),
        .src_msg      (src_msg2),
        .src_read_en  (src_read_en2),
        .book_msg     (book_msg2),
        .book_read_en (book_read_en2),
        .book_empty   (book_empty2),
        .book_busy    (book_busy2),
        .grant_id     (grant_id2),
        .grant_cnt    (grant_cnt2)
    );

    // FIFO models with one cycle read latency.
    logic [MW-1:0] mem [NS][64];
    int wr [NS];
    int rd [NS];

    always_comb begin
        src_empty = '0;
        for (int i = 0; i < NS; i++) src_empty[i] = (rd[i] == wr[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (src_read_en[i] && (rd[i] != wr[i])) begin
                src_msg[i] <= mem[i][rd[i] % 64];
                rd[i]      <= rd[i] + 1;
            end
        end
    end

    function automatic logic [MW-1:0] mk_msg(input logic [7:0] typ, input logic [7:0] side,
                                             input logic [31:0] id, input logic [31:0] px,
                                             input logic [31:0] qty);
        return {typ, side, 16'h0, id, px, qty};
    endfunction

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Advance to the next sampling point and check the always-true properties.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("inv_src_onehot0", 128'($onehot0(src_read_en)), 128'(1'b1));
        chk("inv_no_overlap", 128'(book_read_en && (src_read_en != '0)), 128'(1'b0));
        chk("inv_book_empty", 128'(book_empty), 128'(!book_read_en));
    endtask

    task automatic push(input int s, input logic [MW-1:0] m);
        mem[s][wr[s] % 64] = m;
        wr[s] = wr[s] + 1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_issue(output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (book_read_en) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
        end
        timeout_fail("wait_issue");
    endtask

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (src_read_en != '0) begin
                ok = 1'b1;
                return;
            end
        end
        timeout_fail("wait_pop");
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (src_empty != '1 && i < 200) begin
            tick();
            i++;
        end
        if (src_empty != '1) timeout_fail("drain");
        repeat (6) tick();
    endtask

    typedef struct {
        int         prime;
        logic [3:0] mask;
        logic [3:0] exp_pop;
    } vec_t;

    vec_t          vecs [8];
    logic [3:0]    pop_hist [0:1023];
    bit            busy_hist [0:1023];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, base, r, issued, total, last_src, prev_t, last_t, exp_s, s2, w;
        bit ok;
        int cnt [NS];
        int erd [NS];
        logic [MW-1:0] emem [NS][8];
        logic [MW-1:0] m_a, m_b, m_c, m_ask;

        // {source served last, requesting sources, expected pop}
        vecs[0] = '{0, 4'b1111, 4'b0010};
        vecs[1] = '{1, 4'b0001, 4'b0001};
        vecs[2] = '{2, 4'b1011, 4'b1000};
        vecs[3] = '{3, 4'b0110, 4'b0010};
        vecs[4] = '{1, 4'b1001, 4'b1000};
        vecs[5] = '{2, 4'b0100, 4'b0100};
        vecs[6] = '{3, 4'b1000, 4'b1000};
        vecs[7] = '{0, 4'b0101, 4'b0100};

        reset      = 1'b0;
        book_busy  = 1'b0;
        book_busy2 = 1'b0;
        src_empty2 = '1;
        src_msg2   = {4{128'hDEAD_BEEF_0000_0000_DEAD_BEEF_0000_0000}};

        // Reset state.
        tick();
        tick();
        chk("rst_book_msg", book_msg, '0);
        chk("rst_grant_id", 128'(grant_id), '0);
        chk("rst_grant_cnt", 128'(grant_cnt), '0);
        chk("rst_book_empty", 128'(book_empty), 128'(1'b1));
        reset = 1'b1;

        // Idle with every FIFO empty.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_src_read_en", 128'(src_read_en), '0);
            chk("idle_book_read_en", 128'(book_read_en), '0);
            chk("idle_book_empty", 128'(book_empty), 128'(1'b1));
        end

        // Single message from src0: pop at +1, issue at +3.
        m_a = mk_msg(ADD, BID, 32'h1111_1111, 32'd1000, 32'd10);
        push(0, m_a);
        tick();
        chk("single_pop", 128'(src_read_en), 128'(4'b0001));
        tick();
        chk("single_no_issue_yet", 128'(book_read_en), '0);
        tick();
        chk("single_issue", 128'(book_read_en), 128'(1'b1));
        chk("single_msg", book_msg, m_a);
        chk("single_grant_id", 128'(grant_id), '0);
        tick();
        chk("single_cnt0", 128'(grant_cnt[0]), 128'(1));
        chk("single_msg_hold", book_msg, m_a);
        drain();

        // Three messages in every FIFO, book never busy.
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < NS; s++)
                push(s, mk_msg(ADD, BID, 32'hC000_0000 + 32'(s * 16 + k), 32'd500, 32'd1));
        base   = cyc;
        issued = 0;
        prev_t = -1;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (book_read_en) begin
                chk("rr_order", 128'(grant_id), 128'(issued % NS));
                chk("rr_msg", book_msg, mk_msg(ADD, BID,
                    32'hC000_0000 + 32'((issued % NS) * 16 + issued / NS), 32'd500, 32'd1));
                if (prev_t < 0) chk("rr_first_latency", 128'(cyc - base), 128'(3));
                else chk("rr_spacing", 128'(cyc - prev_t), 128'(5));
                prev_t = cyc;
                issued++;
            end
        end
        chk("rr_issue_count", 128'(issued), 128'(12));
        for (int s = 0; s < NS; s++) chk("rr_grant_cnt", 128'(grant_cnt[s]), 128'(3));

        // Book busy for seven WAIT cycles after src2 is issued.
        m_b = mk_msg(ADD, ASK, 32'h2222_2222, 32'd900, 32'd5);
        m_c = mk_msg(ADD, ASK, 32'h3333_3333, 32'd901, 32'd6);
        push(2, m_b);
        push(3, m_c);
        wait_issue(t, ok);
        if (ok) begin
            chk("busy_first_grant", 128'(grant_id), 128'(2));
            book_busy = 1'b1;
            for (int i = 1; i <= 9; i++) begin
                tick();
                chk("busy_no_pop", 128'(src_read_en), '0);
                if (i == 8) book_busy = 1'b0;
            end
            tick();
            chk("busy_next_pop", 128'(src_read_en), 128'(4'b1000));
        end
        drain();

        // Reset during LOAD discards the message; src0 is served first afterwards.
        m_a = mk_msg(ADD, BID, 32'h4444_4444, 32'd700, 32'd7);
        m_b = mk_msg(ADD, BID, 32'h5555_5555, 32'd701, 32'd8);
        m_c = mk_msg(ADD, BID, 32'h6666_6666, 32'd702, 32'd9);
        push(1, m_a);
        push(1, m_b);
        wait_pop(ok);
        if (ok) chk("rstmid_pop", 128'(src_read_en), 128'(4'b0010));
        tick();
        reset = 1'b0;
        #1;
        chk("rstmid_book_msg", book_msg, '0);
        chk("rstmid_src_read_en", 128'(src_read_en), '0);
        chk("rstmid_book_read_en", 128'(book_read_en), '0);
        chk("rstmid_grant_cnt", 128'(grant_cnt), '0);
        tick();
        reset = 1'b1;
        push(0, m_c);
        wait_issue(t, ok);
        if (ok) begin
            chk("rstmid_src0_first", 128'(grant_id), '0);
            chk("rstmid_src0_msg", book_msg, m_c);
        end
        wait_issue(t, ok);
        if (ok) begin
            chk("rstmid_src1_next", 128'(grant_id), 128'(1));
            chk("rstmid_src1_msg", book_msg, m_b);
        end
        drain();

        // Arbitration vectors.
        for (int v = 0; v < 8; v++) begin
            push(vecs[v].prime, mk_msg(ADD, BID, 32'hB000_0000 + 32'(v), 32'd1, 32'd1));
            wait_issue(t, ok);
            if (ok) chk("vec_prime_grant", 128'(grant_id), 128'(vecs[v].prime));
            tick();
            for (int s = 0; s < NS; s++)
                if (vecs[v].mask[s]) push(s, mk_msg(ADD, ASK, 32'(s), 32'(v), 32'd2));
            wait_pop(ok);
            if (ok) chk("vec_pop", 128'(src_read_en), 128'(vecs[v].exp_pop));
            drain();
        end

        // Randomized loads with random book_busy against the transaction model.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            total = 0;
            for (int s = 0; s < NS; s++) begin
                cnt[s] = int'($urandom_range(0, 5));
                erd[s] = 0;
                total += cnt[s];
            end
            if (total == 0) begin
                cnt[2] = 1;
                total  = 1;
            end
            for (int s = 0; s < NS; s++)
                for (int k = 0; k < cnt[s]; k++) begin
                    emem[s][k] = {$urandom, $urandom, $urandom, $urandom};
                    push(s, emem[s][k]);
                end
            r         = 0;
            issued    = 0;
            last_src  = NS - 1;
            prev_t    = -1;
            last_t    = 0;
            book_busy = ($urandom_range(0, 99) < 45);
            busy_hist[0] = book_busy;
            pop_hist[0]  = '0;
            while (r < 900 && !(issued == total && r > last_t + 8)) begin
                tick();
                r++;
                pop_hist[r] = src_read_en;
                if (book_read_en) begin
                    exp_s = -1;
                    for (int k = 1; k <= NS; k++) begin
                        s2 = (last_src + k) % NS;
                        if (exp_s < 0 && erd[s2] < cnt[s2]) exp_s = s2;
                    end
                    if (exp_s < 0) begin
                        timeout_fail("rand_extra_issue");
                    end else begin
                        chk("rand_grant", 128'(grant_id), 128'(exp_s));
                        chk("rand_msg", book_msg, emem[exp_s][erd[exp_s]]);
                        chk("rand_pop", 128'(pop_hist[r - 2]), 128'(4'b0001 << exp_s));
                        erd[exp_s]++;
                        last_src = exp_s;
                    end
                    if (prev_t < 0) begin
                        chk("rand_first_time", 128'(r), 128'(3));
                    end else begin
                        w = -1;
                        for (int x = prev_t + 1; x < r; x++)
                            if (w < 0 && !busy_hist[x]) w = x;
                        chk("rand_issue_time", 128'(r), 128'(w + 4));
                    end
                    prev_t = r;
                    last_t = r;
                    issued++;
                end
                book_busy    = ($urandom_range(0, 99) < 45);
                busy_hist[r] = book_busy;
            end
            book_busy = 1'b0;
            chk("rand_issue_total", 128'(issued), 128'(total));
            for (int s = 0; s < NS; s++) chk("rand_grant_cnt", 128'(grant_cnt[s]), 128'(cnt[s]));
            drain();
        end

        // FIFO_LAT=2 instance: data appears two cycles after the pop.
        m_ask = mk_msg(ADD, ASK, 32'hAAAA_AAAA, 32'd1100, 32'd15);
        src_empty2 = 4'b1101;
        base = cyc;
        tick();
        chk("lat2_pop", 128'(src_read_en2), 128'(4'b0010));
        src_empty2 = '1;
        tick();
        chk("lat2_pop_once", 128'(src_read_en2), '0);
        tick();
        chk("lat2_no_issue_yet", 128'(book_read_en2), '0);
        src_msg2[1] = m_ask;
        tick();
        src_msg2[1] = 128'hDEAD_BEEF_0000_0000_DEAD_BEEF_0000_0000;
        chk("lat2_issue_time", 128'(book_read_en2), 128'(1'b1));
        chk("lat2_latency", 128'(cyc - base), 128'(4));
        chk("lat2_msg", book_msg2, m_ask);
        chk("lat2_grant_id", 128'(grant_id2), 128'(1));
        tick();
        chk("lat2_grant_cnt", 128'(grant_cnt2[1]), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
